// File: rtl/mig_ui_pkg.sv
// Shared definitions for the MIG UI multi-port arbiter: MIG command codes,
// the arbiter state encoding and the port-index width helper.
package mig_ui_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  // Width of a port index; a single port still needs a one-bit index.
  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mig_rd_tag_fifo.sv
// Tag FIFO holding the issuing port index of every outstanding read.
// Entries come back in MIG return order, so a plain FIFO suffices.
// Push and pop in the same cycle are allowed, including when full.
// DEPTH must be a power of two, at least 2.
module mig_rd_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count decide which entries are valid, and a reset-free array maps to RAM.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mig_ui_arbiter.sv
// Multi-port round-robin front-end for the DDR3 MIG user interface.
// One request at a time is latched and driven onto app_* until both the
// command and (for writes) the data handshakes have completed. Reads are
// tagged with their port so returning data can be routed back.
// Optional statistics counters are built when MIG_UI_ARB_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
module mig_ui_arbiter
  import mig_ui_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int RD_TAG_DEPTH   = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                init_calib_complete,
  input  logic [NUM_PORTS-1:0]                req_valid,
  input  logic [NUM_PORTS-1:0]                req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_PORTS*APP_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]                req_ready,
  output logic [NUM_PORTS-1:0]                rd_valid,
  output logic [APP_DATA_WIDTH-1:0]           rd_data,
  output logic                                rd_err,
  output logic [ADDR_WIDTH-1:0]               app_addr,
  output logic [2:0]                          app_cmd,
  output logic                                app_en,
  input  logic                                app_rdy,
  output logic [APP_DATA_WIDTH-1:0]           app_wdf_data,
  output logic                                app_wdf_wren,
  output logic                                app_wdf_end,
  output logic [APP_DATA_WIDTH/8-1:0]         app_wdf_mask,
  input  logic                                app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]           app_rd_data,
  input  logic                                app_rd_data_valid,
  output logic [31:0]                         stat_wr_cnt,
  output logic [31:0]                         stat_rd_cnt,
  output logic [31:0]                         stat_stall_cnt
);

  localparam int PW = port_idx_w(NUM_PORTS);

  arb_state_t                state;
  logic [PW-1:0]             last_grant;
  logic [PW-1:0]             cur_port;
  logic [ADDR_WIDTH-1:0]     cur_addr;
  logic [APP_DATA_WIDTH-1:0] cur_wdata;
  logic                      cur_write;
  logic [2:0]                cur_cmd;
  logic                      cmd_done;
  logic                      wdf_done;

  logic [NUM_PORTS-1:0]      elig;
  logic                      grant_found;
  logic [PW-1:0]             grant_idx;
  logic [PW-1:0]             cand;

  logic                      issuing;
  logic                      cmd_hs;
  logic                      wdf_hs;
  logic                      xfer_done;

  logic                      tag_push;
  logic [PW-1:0]             tag_out;
  logic                      tag_full;
  logic                      tag_empty;

  assign issuing      = (state == ST_ISSUE);
  assign app_en       = issuing & ~cmd_done;
  assign app_wdf_wren = issuing & ~wdf_done;
  assign app_wdf_end  = app_wdf_wren;
  assign cmd_hs       = app_en & app_rdy;
  assign wdf_hs       = app_wdf_wren & app_wdf_rdy;
  assign xfer_done    = issuing & (cmd_done | cmd_hs) & (wdf_done | wdf_hs);

  assign app_addr     = cur_addr;
  assign app_cmd      = cur_cmd;
  assign app_wdf_data = cur_wdata;
  assign app_wdf_mask = '0;

  // Per-port eligibility: calibrated, requesting, and reads need a free tag.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig[p] = init_calib_complete & req_valid[p] & (req_write[p] | ~tag_full);
    end
  end

  // Round-robin search starting one past the last granted port.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(last_grant) + i) % NUM_PORTS);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Completion strobe back to the port whose request is being issued.
  always_comb begin
    req_ready = '0;
    if (xfer_done) req_ready[cur_port] = 1'b1;
  end

  // Arbiter FSM: latch a granted request, then hold app_* until it completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= PW'(NUM_PORTS - 1);
      cur_port   <= '0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      cur_write  <= 1'b0;
      cur_cmd    <= CMD_WRITE;
      cmd_done   <= 1'b0;
      wdf_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            state      <= ST_ISSUE;
            last_grant <= grant_idx;
            cur_port   <= grant_idx;
            cur_addr   <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            cur_wdata  <= req_wdata[int'(grant_idx)*APP_DATA_WIDTH +: APP_DATA_WIDTH];
            cur_write  <= req_write[grant_idx];
            cur_cmd    <= req_write[grant_idx] ? CMD_WRITE : CMD_READ;
            cmd_done   <= 1'b0;
            // Reads have no data phase, so that half is already satisfied.
            wdf_done   <= ~req_write[grant_idx];
          end
        end
        ST_ISSUE: begin
          if (cmd_hs) cmd_done <= 1'b1;
          if (wdf_hs) wdf_done <= 1'b1;
          if (xfer_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tag_push = cmd_hs & ~cur_write;

  mig_rd_tag_fifo #(
    .DEPTH (RD_TAG_DEPTH),
    .WIDTH (PW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (cur_port),
    .pop       (app_rd_data_valid),
    .pop_data  (tag_out),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Read return: route each beat to the oldest outstanding tag; flag orphans.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= '0;
      if (app_rd_data_valid) begin
        if (tag_empty) begin
          rd_err <= 1'b1;
        end else begin
          rd_valid[tag_out] <= 1'b1;
          rd_data           <= app_rd_data;
        end
      end
    end
  end

`ifdef MIG_UI_ARB_STATS_EN
  // Wrapping transaction and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_cnt    <= '0;
      stat_rd_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (xfer_done &  cur_write) stat_wr_cnt    <= stat_wr_cnt + 32'd1;
      if (xfer_done & ~cur_write) stat_rd_cnt    <= stat_rd_cnt + 32'd1;
      if (app_en & ~app_rdy)      stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`else
  assign stat_wr_cnt    = '0;
  assign stat_rd_cnt    = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mig_ui_arbiter.sv
// Directed bench for mig_ui_arbiter (2 ports, 28-bit address, 128-bit data,
// 16 read tags). Inputs change just after the rising edge or on the falling
// edge; outputs are sampled on the falling edge.
module tb_mig_ui_arbiter;

  localparam int NP = 2;
  localparam int AW = 28;
  localparam int DW = 128;

  logic             clk;
  logic             rst;
  logic             init_calib_complete;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_write;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    rd_valid;
  logic [DW-1:0]    rd_data;
  logic             rd_err;
  logic [AW-1:0]    app_addr;
  logic [2:0]       app_cmd;
  logic             app_en;
  logic             app_rdy;
  logic [DW-1:0]    app_wdf_data;
  logic             app_wdf_wren;
  logic             app_wdf_end;
  logic [DW/8-1:0]  app_wdf_mask;
  logic             app_wdf_rdy;
  logic [DW-1:0]    app_rd_data;
  logic             app_rd_data_valid;
  logic [31:0]      stat_wr_cnt;
  logic [31:0]      stat_rd_cnt;
  logic [31:0]      stat_stall_cnt;

  int checks = 0;
  int errors = 0;

  mig_ui_arbiter #(
    .NUM_PORTS      (NP),
    .ADDR_WIDTH     (AW),
    .APP_DATA_WIDTH (DW),
    .RD_TAG_DEPTH   (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (init_calib_complete),
    .req_valid           (req_valid),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_ready           (req_ready),
    .rd_valid            (rd_valid),
    .rd_data             (rd_data),
    .rd_err              (rd_err),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .stat_wr_cnt         (stat_wr_cnt),
    .stat_rd_cnt         (stat_rd_cnt),
    .stat_stall_cnt      (stat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] WD0 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [DW-1:0] WD1 = 128'h5A5A_9999_8888_7777_6666_5555_4444_3333;
  localparam logic [DW-1:0] D1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] D2  = 128'hDEAD_BEEF_0000_1111_CAFE_F00D_2222_3333;
  localparam logic [DW-1:0] D3  = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
  localparam logic [DW-1:0] D4  = 128'h4444_0000_4444_0000_4444_0000_4444_0000;
  localparam logic [DW-1:0] D5  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;

  int         en_seen;
  int         n_done;
  int         c0;
  int         c1;
  int         addr_bad;
  logic [9:0] order;

  initial begin
    rst                 = 1'b1;
    init_calib_complete = 1'b0;
    req_valid           = '0;
    req_write           = '0;
    req_addr            = '0;
    req_wdata           = '0;
    app_rdy             = 1'b0;
    app_wdf_rdy         = 1'b0;
    app_rd_data         = '0;
    app_rd_data_valid   = 1'b0;

    // ---- Reset values ----
    repeat (3) cycle();
    @(negedge clk);
    check("rst_app_en", app_en, 0);
    check("rst_app_cmd", app_cmd, 0);
    check("rst_app_addr", app_addr, 0);
    check("rst_wdf_wren", app_wdf_wren, 0);
    check("rst_wdf_end", app_wdf_end, 0);
    check("rst_wdf_mask", app_wdf_mask, 0);
    check("rst_wdf_data", app_wdf_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_stat_wr", stat_wr_cnt, 0);
    check("rst_stat_rd", stat_rd_cnt, 0);
    check("rst_stat_stall", stat_stall_cnt, 0);
    cycle();
    rst = 1'b0;

    // ---- Calibration gate ----
    req_addr[0 +: AW]  = 28'h0123456;
    req_wdata[0 +: DW] = WD0;
    req_write          = 2'b01;
    req_valid          = 2'b01;
    app_rdy            = 1'b1;
    app_wdf_rdy        = 1'b1;
    en_seen            = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (app_en) en_seen++;
      cycle();
    end
    check("calib_no_en_100", en_seen, 0);
    init_calib_complete = 1'b1;
    @(negedge clk);
    check("calib_grant_not_yet", app_en, 0);
    cycle();
    @(negedge clk);
    check("calib_app_en", app_en, 1);
    check("calib_app_cmd_wr", app_cmd, 3'b000);
    check("calib_app_addr", app_addr, 28'h0123456);
    check("calib_wdf_data", app_wdf_data, WD0);
    check("calib_wdf_wren", app_wdf_wren, 1);
    check("calib_wdf_end", app_wdf_end, 1);
    check("calib_req_ready", req_ready, 2'b01);
    cycle();
    req_valid = 2'b00;
    @(negedge clk);
    check("calib_back_idle", app_en, 0);
    cycle();

    // ---- Split write handshake: data accepted 3 cycles after command ----
    req_addr[0 +: AW] = 28'h0000200;
    app_wdf_rdy       = 1'b0;
    req_valid         = 2'b01;
    cycle();
    @(negedge clk);
    check("split_c1_en", app_en, 1);
    check("split_c1_wren", app_wdf_wren, 1);
    check("split_c1_ready", req_ready, 0);
    cycle();
    @(negedge clk);
    check("split_c2_en", app_en, 0);
    check("split_c2_wren", app_wdf_wren, 1);
    check("split_c2_ready", req_ready, 0);
    cycle();
    @(negedge clk);
    check("split_c3_wren", app_wdf_wren, 1);
    check("split_c3_addr", app_addr, 28'h0000200);
    check("split_c3_ready", req_ready, 0);
    cycle();
    app_wdf_rdy = 1'b1;
    @(negedge clk);
    check("split_c4_wren", app_wdf_wren, 1);
    check("split_c4_ready", req_ready, 2'b01);
    cycle();
    req_valid = 2'b00;
    @(negedge clk);
    check("split_done_wren", app_wdf_wren, 0);
    check("split_done_ready", req_ready, 0);
    cycle();

    // ---- Round-robin: both ports write continuously (port 0 granted last) ----
    req_addr[AW +: AW]  = 28'h0000111;
    req_wdata[DW +: DW] = WD1;
    req_write           = 2'b11;
    req_valid           = 2'b11;
    n_done              = 0;
    c0                  = 0;
    addr_bad            = 0;
    order               = '0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      @(negedge clk);
      if (req_ready != 2'b00) begin
        if (n_done < 10) order[n_done] = req_ready[1];
        if (req_ready[0]) c0++;
        if (req_ready[1] && app_addr != 28'h0000111) addr_bad++;
        if (req_ready[0] && app_addr != 28'h0000200) addr_bad++;
        n_done++;
      end
    end
    req_valid = 2'b00;
    check("rr_total_10", n_done, 10);
    check("rr_port0_5", c0, 5);
    check("rr_order", order, 10'b0101010101);
    check("rr_addr_route", addr_bad, 0);
    cycle();

    // ---- Read routing: port 1 reads A, then port 0 reads B ----
    req_addr[AW +: AW] = 28'h00000A0;
    req_addr[0 +: AW]  = 28'h00000B0;
    req_write          = 2'b00;
    req_valid          = 2'b11;
    cycle();
    @(negedge clk);
    check("rd_p1_ready", req_ready, 2'b10);
    check("rd_p1_cmd", app_cmd, 3'b001);
    check("rd_p1_addr", app_addr, 28'h00000A0);
    check("rd_p1_no_wren", app_wdf_wren, 0);
    req_valid = 2'b01;
    cycle();
    cycle();
    @(negedge clk);
    check("rd_p0_ready", req_ready, 2'b01);
    check("rd_p0_addr", app_addr, 28'h00000B0);
    req_valid = 2'b00;
    cycle();
    app_rd_data       = D1;
    app_rd_data_valid = 1'b1;
    @(negedge clk);
    check("rd_latency", rd_valid, 2'b00);
    cycle();
    app_rd_data = D2;
    @(negedge clk);
    check("rd_beat1_valid", rd_valid, 2'b10);
    check("rd_beat1_data", rd_data, D1);
    cycle();
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    check("rd_beat2_valid", rd_valid, 2'b01);
    check("rd_beat2_data", rd_data, D2);
    cycle();
    @(negedge clk);
    check("rd_after_valid", rd_valid, 2'b00);
    check("rd_no_err", rd_err, 0);
    cycle();

    // ---- Tag FIFO full: 16 reads from port 1 ----
    req_addr[AW +: AW] = 28'h0000C00;
    req_write          = 2'b00;
    req_valid          = 2'b10;
    c1                 = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      @(negedge clk);
      if (req_ready[1]) c1++;
    end
    check("full_16_reads", c1, 16);
    // 17th read pending on port 1 while port 0 writes.
    req_write = 2'b01;
    req_valid = 2'b11;
    c0        = 0;
    c1        = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      @(negedge clk);
      if (req_ready[0]) c0++;
      if (req_ready[1]) c1++;
    end
    check("full_writes_proceed", c0, 3);
    check("full_read_stalled", c1, 0);
    req_valid         = 2'b10;
    app_rd_data       = D3;
    app_rd_data_valid = 1'b1;
    cycle();
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    check("full_pop_no_grant_yet", app_en, 0);
    check("full_pop_valid", rd_valid, 2'b10);
    check("full_pop_data", rd_data, D3);
    cycle();
    app_rd_data       = D4;
    app_rd_data_valid = 1'b1;
    @(negedge clk);
    check("full_read_granted", app_en, 1);
    check("full_read_cmd", app_cmd, 3'b001);
    check("full_read_ready", req_ready, 2'b10);
    cycle();
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    check("pushpop_rd_valid", rd_valid, 2'b10);
    check("pushpop_rd_data", rd_data, D4);
    cycle();
    @(negedge clk);
    check("pushpop_one_free", req_ready, 2'b10);
    cycle();
    cycle();
    @(negedge clk);
    check("refull_stall_en", app_en, 0);
    check("refull_stall_ready", req_ready, 0);
    req_valid = 2'b00;
    rst       = 1'b1;

    // ---- Reset clears FIFO; orphan return sets sticky rd_err ----
    cycle();
    @(negedge clk);
    check("rst1_app_en", app_en, 0);
    check("rst1_rd_valid", rd_valid, 0);
    check("rst1_rd_data", rd_data, 0);
    rst = 1'b0;
    cycle();
    app_rd_data       = D5;
    app_rd_data_valid = 1'b1;
    @(negedge clk);
    check("err_not_yet", rd_err, 0);
    cycle();
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    check("err_set", rd_err, 1);
    check("err_no_rd_valid", rd_valid, 0);
    repeat (3) cycle();
    @(negedge clk);
    check("err_sticky", rd_err, 1);

    // ---- Reset mid-ISSUE ----
    req_addr[0 +: AW] = 28'h0ABCDEF;
    req_write         = 2'b01;
    req_valid         = 2'b01;
    app_rdy           = 1'b0;
    app_wdf_rdy       = 1'b0;
    cycle();
    @(negedge clk);
    check("mid_issue_en", app_en, 1);
    check("mid_issue_addr", app_addr, 28'h0ABCDEF);
    rst = 1'b1;
    cycle();
    @(negedge clk);
    check("rst2_app_en", app_en, 0);
    check("rst2_wdf_wren", app_wdf_wren, 0);
    check("rst2_wdf_end", app_wdf_end, 0);
    check("rst2_app_addr", app_addr, 0);
    check("rst2_app_cmd", app_cmd, 0);
    check("rst2_wdf_data", app_wdf_data, 0);
    check("rst2_req_ready", req_ready, 0);
    check("rst2_rd_err", rd_err, 0);
    req_valid   = 2'b00;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    rst         = 1'b0;
    cycle();
    @(negedge clk);
    check("rst2_req_dropped", app_en, 0);
    req_valid = 2'b11;
    cycle();
    @(negedge clk);
    check("rst2_port0_first", req_ready, 2'b01);
    check("rst2_port0_addr", app_addr, 28'h0ABCDEF);
    req_valid = 2'b00;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
